// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller for the MEM stage.
// Read hits complete combinationally; misses and stores go to main memory over a strobe/ready handshake.
module dcache_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int INDEX_BITS = 3
) (
  input  logic                  inp_clk,
  input  logic                  inp_rst,
  input  logic [ADDR_WIDTH-1:0] inp_address,
  input  logic [DATA_WIDTH-1:0] inp_writeData,
  input  logic                  inp_memRead,
  input  logic                  inp_memWrite,
  output logic [DATA_WIDTH-1:0] out_readData,
  output logic                  out_hit,
  output logic [ADDR_WIDTH-1:0] out_memAddress,
  output logic [DATA_WIDTH-1:0] out_memWriteData,
  output logic                  out_memRead,
  output logic                  out_memWrite,
  input  logic                  inp_memReady,
  input  logic [DATA_WIDTH-1:0] inp_memReadData
);

  localparam int LINES     = 1 << INDEX_BITS;
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, RFILL, WTHRU, DONE} state_t;

  state_t state_q, state_d;

  logic [LINES-1:0]      valid_q, valid_d;
  logic [TAG_WIDTH-1:0]  tag_q  [LINES];
  logic [TAG_WIDTH-1:0]  tag_d  [LINES];
  logic [DATA_WIDTH-1:0] data_q [LINES];
  logic [DATA_WIDTH-1:0] data_d [LINES];

  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_rd_q, mem_rd_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [DATA_WIDTH-1:0] fill_data_q, fill_data_d;

  logic [INDEX_BITS-1:0] req_index, pend_index;
  logic [TAG_WIDTH-1:0]  req_tag, pend_tag;
  logic                  req_hit, pend_hit;

  // The incoming request is looked up directly; the pending transaction uses its latched address.
  assign req_index  = inp_address[INDEX_BITS-1:0];
  assign req_tag    = inp_address[ADDR_WIDTH-1:INDEX_BITS];
  assign req_hit    = valid_q[req_index] && (tag_q[req_index] == req_tag);

  assign pend_index = mem_addr_q[INDEX_BITS-1:0];
  assign pend_tag   = mem_addr_q[ADDR_WIDTH-1:INDEX_BITS];
  assign pend_hit   = valid_q[pend_index] && (tag_q[pend_index] == pend_tag);

  assign out_memAddress   = mem_addr_q;
  assign out_memWriteData = mem_wdata_q;
  assign out_memRead      = mem_rd_q;
  assign out_memWrite     = mem_wr_q;

  always_ff @(posedge inp_clk) begin
    if (inp_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (inp_memWrite) begin
          state_d = WTHRU;
        end else if (inp_memRead && !req_hit) begin
          state_d = RFILL;
        end
      end
      RFILL: begin
        if (inp_memReady) begin
          state_d = DONE;
        end
      end
      WTHRU: begin
        if (inp_memReady) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A simultaneous read and write is serviced as a write, so any write stalls in IDLE.
  always_comb begin
    out_hit      = 1'b0;
    out_readData = data_q[req_index];
    if (!inp_rst) begin
      case (state_q)
        IDLE: begin
          out_hit = !inp_memWrite && (!inp_memRead || req_hit);
        end
        DONE: begin
          out_hit      = 1'b1;
          out_readData = fill_data_q;
        end
        default: begin
          out_hit = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    fill_data_d = fill_data_q;
    case (state_q)
      IDLE: begin
        if (inp_memWrite) begin
          mem_addr_d  = inp_address;
          mem_wdata_d = inp_writeData;
          mem_wr_d    = 1'b1;
        end else if (inp_memRead && !req_hit) begin
          mem_addr_d = inp_address;
          mem_rd_d   = 1'b1;
        end
      end
      RFILL: begin
        // Nothing is ever dirty, so a fill simply replaces whatever line sits at this index.
        if (inp_memReady) begin
          valid_d[pend_index] = 1'b1;
          tag_d[pend_index]   = pend_tag;
          data_d[pend_index]  = inp_memReadData;
          fill_data_d         = inp_memReadData;
          mem_rd_d            = 1'b0;
        end
      end
      WTHRU: begin
        if (inp_memReady) begin
          if (pend_hit) begin
            data_d[pend_index] = mem_wdata_q;
          end
          mem_wr_d = 1'b0;
        end
      end
      default: begin
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge inp_clk) begin
    if (inp_rst) begin
      valid_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      fill_data_q <= '0;
    end else begin
      valid_q     <= valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      fill_data_q <= fill_data_d;
    end
  end

  // Tag and data arrays carry no reset; a transaction cut short by reset must not touch them.
  always_ff @(posedge inp_clk) begin
    if (!inp_rst) begin
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

endmodule
